pack_sync: RTL
==============

Name: pack_sync

Overview:
- Parametrised preamble synchroniser and frame delimiter for the DeFEC receive path, placed between the soft demapper and the decoder.
- Hard-slices soft symbols and correlates a sliding window against a configurable preamble.
- On detection, gates out a fixed-length payload with start/end markers and returns to search.
- Next generation of the earlier fixed-128 finder: generic length, width, threshold and payload length; adds framing FSM, warm-up guard and status outputs.

Parameters:
- PREA_LEN, 128: preamble length in symbols, 8..256.
- DAT_W, 5: soft symbol width; MSB is the sign.
- THRESH, 80: detection threshold on the signed correlation, 1..PREA_LEN.
- PAY_LEN, 1024: payload symbols per frame, at least 1.
- PREAMBLE, PREA_LEN-bit vector, default all zeros, overridden per use: bit PREA_LEN-1 is transmitted first.
- CNT_W, 16: width of the frame counter.

Ports:
- iclk  in  1  clock.
- irst  in  1  reset; synchronous, active-high, sampled on rising iclk.
- idat  in  DAT_W  soft symbol.
- ival  in  1  idat qualifier; any duty cycle allowed.
- odat  out  DAT_W  payload soft symbol.
- oval  out  1  odat valid; payload symbols only.
- osop  out  1  first payload symbol of a frame; qualified by oval.
- oeop  out  1  last payload symbol of a frame; qualified by oval.
- olock  out  1  high while the FSM is in PAYLOAD.
- ocorr  out  ACC_W  signed correlation of the last evaluated window; ACC_W = $clog2(PREA_LEN)+2.
- ofrm_cnt  out  CNT_W  number of frames detected; wraps.

Behaviour:
- Hard bit = ~idat[DAT_W-1], so a positive soft value gives 1.
- On every ival, a PREA_LEN-bit shift register sr shifts left, and the new bit enters sr[0].
- The candidate window is {sr[PREA_LEN-2:0], new bit}, evaluated combinationally in the ival cycle.
- corr = 2*popcount(~(window ^ PREAMBLE)) - PREA_LEN, signed ACC_W, range -PREA_LEN..+PREA_LEN.
- ocorr is registered whenever ival is high and holds otherwise.
- Warm-up: a fill counter saturates at PREA_LEN valid symbols. No detection is allowed until the window is full, i.e. the first possible hit is on the PREA_LEN-th symbol after reset.
- FSM has two states, SEARCH and PAYLOAD; reset state is SEARCH.
- SEARCH to PAYLOAD: ival and window full and corr >= THRESH, at the same edge.
  - Payload counter loads 0.
  - ofrm_cnt increments.
  - The preamble-completing symbol itself is not output.
- In PAYLOAD, each ival symbol is output one cycle later: oval=1, odat=idat.
  - osop=1 when payload count = 0.
  - oeop=1 when count = PAY_LEN-1.
  - On the oeop symbol the FSM returns to SEARCH at the same edge.
- PAY_LEN=1: osop and oeop assert on the same symbol.
- Correlation is ignored in PAYLOAD. sr keeps shifting, so search resumes on the symbol immediately after oeop, with no refill.
- Back-to-back frames: a preamble that ends on symbol k after oeop is detected normally.
- ival gaps inside PAYLOAD: FSM and counters hold; oval is low during gaps.
- Output latency is exactly 1 cycle from an ival payload symbol to oval. osop, oeop and odat are registered with oval.
- Reset values: odat=0, oval=0, osop=0, oeop=0, olock=0, ocorr=0, ofrm_cnt=0; also sr=0 and fill count=0.
- Reset mid-frame aborts the frame with no oeop, returns to SEARCH and restarts warm-up.
- ofrm_cnt wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro PACK_SYNC_PHASE_INV_EN.
- When defined: SEARCH also triggers on corr <= -THRESH, which latches an inversion flag for the frame. Payload odat is then two's-complement negated, saturating the most negative value to the most positive. The flag clears on return to SEARCH and on reset.
- When undefined: only the positive threshold triggers, and odat always equals idat.

Decomposition:
- Package pack_sync_pkg holds:
  - state enum (SEARCH, PAYLOAD);
  - function acc_w(prea_len);
  - soft negate-saturate function;
  - default preamble constant.
- One sub-module, pack_corr: shift register, warm-up counter and popcount correlator producing corr and a window-full flag. The FSM and output stage stay in pack_sync.

Test Plan:
- PREA_LEN=16, THRESH=16, PAY_LEN=4. Send the exact preamble then 4 symbols 1,2,3,4 with ival=1 → oval on those 4, odat=1..4, osop with odat=1, oeop with odat=4, ofrm_cnt=1, ocorr=16.
- Preamble with 3 bit errors, THRESH=10 (corr=10) → detection. With 4 errors (corr=8) → no oval, ofrm_cnt=0.
- Preamble sent from reset, but only 15 symbols after irst deasserts → no detection. The 16th symbol completes the window → detection.
- PAY_LEN=1 and two back-to-back frames → two single-symbol outputs, each with osop=oeop=1; ofrm_cnt=2.
- ival toggling 1/0 through the payload → oval pulses align 1 cycle after each ival; counts are unaffected by gaps.
- irst asserted after 2 of 4 payload symbols → all outputs 0 next cycle, no oeop. A fresh frame sent afterwards is detected normally.
- With PACK_SYNC_PHASE_INV_EN: inverted preamble (corr=-16), payload +5 and -16 (DAT_W=5) → odat -5 and +15.

Source files
------------

// File: rtl/pack_sync_pkg.sv
// Shared types and helpers for the preamble synchroniser / frame delimiter.
package pack_sync_pkg;

  typedef enum logic {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam int MAX_PREA_LEN = 256;
  localparam logic [MAX_PREA_LEN-1:0] DEF_PREAMBLE = '0;

  function automatic int acc_w(input int prea_len);
    return $clog2(prea_len) + 2;
  endfunction

  // v holds a w-bit two's-complement value, zero-extended; the most negative code maps to the most positive.
  function automatic logic [31:0] soft_neg_sat(input logic [31:0] v, input int w);
    logic [31:0] mask;
    logic [31:0] min_v;
    mask  = (32'(1) << w) - 32'(1);
    min_v = 32'(1) << (w - 1);
    if ((v & mask) == min_v) return min_v - 32'(1);
    return (~v + 32'(1)) & mask;
  endfunction

endpackage

// File: rtl/pack_corr.sv
// Hard-bit shift register, warm-up counter and popcount correlator.
// corr/full are combinational on the current symbol; state advances only on ival.
module pack_corr
  import pack_sync_pkg::*;
#(
  parameter int                  PREA_LEN = 128,
  parameter logic [PREA_LEN-1:0] PREAMBLE = '0,
  parameter int                  ACC_W    = acc_w(PREA_LEN)
) (
  input  logic                    iclk,
  input  logic                    irst,
  input  logic                    hbit,
  input  logic                    ival,
  output logic signed [ACC_W-1:0] corr,
  output logic                    full
);

  localparam int FILL_W = $clog2(PREA_LEN + 1);

  logic [PREA_LEN-1:0] sr;
  logic [PREA_LEN-1:0] win;
  logic [FILL_W-1:0]   fill;
  logic [ACC_W-1:0]    pc;

  assign win  = {sr[PREA_LEN-2:0], hbit};
  // Full means the incoming symbol completes a window of real symbols.
  assign full = (fill >= FILL_W'(PREA_LEN - 1));

  always_comb begin
    pc = '0;
    for (int i = 0; i < PREA_LEN; i++) begin
      pc = pc + ACC_W'(win[i] ~^ PREAMBLE[i]);
    end
    corr = {pc[ACC_W-2:0], 1'b0} - ACC_W'(PREA_LEN);
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      sr   <= '0;
      fill <= '0;
    end else if (ival) begin
      sr <= win;
      if (fill != FILL_W'(PREA_LEN)) fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/pack_sync.sv
// Preamble synchroniser + fixed-length frame gate; 1-cycle ival->oval latency, no backpressure.
// Optional PACK_SYNC_PHASE_INV_EN: also lock on inverted preamble and negate that frame's payload.
module pack_sync
  import pack_sync_pkg::*;
#(
  parameter int                  PREA_LEN = 128,
  parameter int                  DAT_W    = 5,
  parameter int                  THRESH   = 80,
  parameter int                  PAY_LEN  = 1024,
  parameter logic [PREA_LEN-1:0] PREAMBLE = DEF_PREAMBLE[PREA_LEN-1:0],
  parameter int                  CNT_W    = 16,
  localparam int                 ACC_W    = acc_w(PREA_LEN)
) (
  input  logic                    iclk,
  input  logic                    irst,
  input  logic [DAT_W-1:0]        idat,
  input  logic                    ival,
  output logic [DAT_W-1:0]        odat,
  output logic                    oval,
  output logic                    osop,
  output logic                    oeop,
  output logic                    olock,
  output logic signed [ACC_W-1:0] ocorr,
  output logic [CNT_W-1:0]        ofrm_cnt
);

  localparam int PC_W = (PAY_LEN > 1) ? $clog2(PAY_LEN) : 1;
  localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THRESH);

  state_t                  state, state_d;
  logic [PC_W-1:0]         pay_cnt, pay_cnt_d;
  logic [CNT_W-1:0]        frm_cnt_d;
  logic                    oval_d, osop_d, oeop_d;
  logic [DAT_W-1:0]        odat_d;
  logic [DAT_W-1:0]        pay_dat;
  logic signed [ACC_W-1:0] corr;
  logic                    full;
  logic                    hit_pos;
  logic                    hit;

  pack_corr #(
    .PREA_LEN (PREA_LEN),
    .PREAMBLE (PREAMBLE),
    .ACC_W    (ACC_W)
  ) u_corr (
    .iclk (iclk),
    .irst (irst),
    .hbit (~idat[DAT_W-1]),
    .ival (ival),
    .corr (corr),
    .full (full)
  );

  assign hit_pos = (corr >= THR_P);

`ifdef PACK_SYNC_PHASE_INV_EN
  localparam logic signed [ACC_W-1:0] THR_N = -THR_P;
  logic inv, inv_d;
  assign hit     = hit_pos || (corr <= THR_N);
  assign pay_dat = inv ? DAT_W'(soft_neg_sat(32'(idat), DAT_W)) : idat;
`else
  assign hit     = hit_pos;
  assign pay_dat = idat;
`endif

  always_comb begin
    state_d   = state;
    pay_cnt_d = pay_cnt;
    frm_cnt_d = ofrm_cnt;
    oval_d    = 1'b0;
    osop_d    = 1'b0;
    oeop_d    = 1'b0;
    odat_d    = odat;
`ifdef PACK_SYNC_PHASE_INV_EN
    inv_d     = inv;
`endif
    case (state)
      SEARCH: begin
        if (ival && full && hit) begin
          state_d   = PAYLOAD;
          pay_cnt_d = '0;
          frm_cnt_d = ofrm_cnt + CNT_W'(1);
`ifdef PACK_SYNC_PHASE_INV_EN
          inv_d     = ~hit_pos;
`endif
        end
      end
      PAYLOAD: begin
        // Correlation is ignored here; the window keeps sliding so search resumes without refill.
        if (ival) begin
          oval_d = 1'b1;
          osop_d = (pay_cnt == '0);
          oeop_d = (pay_cnt == PC_W'(PAY_LEN - 1));
          odat_d = pay_dat;
          if (oeop_d) begin
            state_d = SEARCH;
`ifdef PACK_SYNC_PHASE_INV_EN
            inv_d   = 1'b0;
`endif
          end else begin
            pay_cnt_d = pay_cnt + PC_W'(1);
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state    <= SEARCH;
      pay_cnt  <= '0;
      ofrm_cnt <= '0;
      odat     <= '0;
      oval     <= 1'b0;
      osop     <= 1'b0;
      oeop     <= 1'b0;
      ocorr    <= '0;
`ifdef PACK_SYNC_PHASE_INV_EN
      inv      <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      pay_cnt  <= pay_cnt_d;
      ofrm_cnt <= frm_cnt_d;
      odat     <= odat_d;
      oval     <= oval_d;
      osop     <= osop_d;
      oeop     <= oeop_d;
      if (ival) ocorr <= corr;
`ifdef PACK_SYNC_PHASE_INV_EN
      inv      <= inv_d;
`endif
    end
  end

  assign olock = (state == PAYLOAD);

endmodule
